booth_mul_sequencer: RTL
========================

# booth_mul_sequencer

Front-end sequencer and result buffer for the signed Booth multiplier. Accepts a signed operand pair over a valid/ready handshake, drives the multiplier's start / shared `data_in` load sequence (multiplicand, then multiplier), waits for `done`, and captures the `2*SIZE`-bit product into a one-entry output register with its own valid/ready handshake. It then returns the multiplier to its idle state for the next operation. It sits directly upstream and downstream of the multiplier. It also gives that datapath a defined power-up state and a hang watchdog.

## Interface
- `SIZE`, 8: operand width; product is `2*SIZE`.
- `TIMEOUT`, `SIZE+8`: maximum cycles spent in WAIT before abort.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  sequencer can accept a pair.
- `in_a`  in  `SIZE`  multiplicand, two's complement.
- `in_b`  in  `SIZE`  multiplier, two's complement.
- `out_valid`  out  1  product register full.
- `out_ready`  in  1  consumer takes product.
- `out_product`  out  `2*SIZE`  signed product `in_a*in_b`.
- `err`  out  1  sticky watchdog flag; cleared only by reset.
- `mul_start`  out  1  to multiplier `start`.
- `mul_reset`  out  1  to multiplier `reset` (active-high, synchronous in multiplier).
- `mul_data`  out  `SIZE`  to multiplier `data_in`.
- `mul_done`  in  1  from multiplier `done`.
- `mul_product`  in  `2*SIZE`  from multiplier `data_out`.

## Operation
- States: INIT, IDLE, START, LOAD_A, LOAD_B, WAIT, RECOVER.
- Reset (`reset_n`=0): state INIT; `a_reg`, `b_reg`, `out_product` cleared to 0; `out_valid`=0; `err`=0; wait counter 0.
- Outputs are Moore-decoded from state:
  - INIT and RECOVER: `mul_reset`=1.
  - START: `mul_start`=1.
  - LOAD_A: `mul_data`=`a_reg`.
  - LOAD_B: `mul_data`=`b_reg`.
  - All other states and signals: 0.
- INIT -> IDLE after 1 cycle. This forces the multiplier's unreset state register to idle.
- `in_ready` = (state==IDLE) && (!`out_valid` || `out_ready`).
- IDLE: on `in_valid && in_ready`, capture `in_a`/`in_b` into `a_reg`/`b_reg` and go to START; otherwise stay.
- START -> LOAD_A -> LOAD_B -> WAIT, one cycle each, unconditionally.
- WAIT:
  - Wait counter increments each cycle.
  - On `mul_done`=1: capture `mul_product` into `out_product`, set `out_valid`, go to RECOVER.
  - If counter reaches `TIMEOUT` without `mul_done`: set `err`, go to RECOVER, `out_valid` unchanged.
- RECOVER -> IDLE after 1 cycle. The wait counter clears on leaving WAIT.
- Output register:
  - `out_valid` clears on `out_valid && out_ready` unless a capture occurs in the same cycle.
  - `out_product` holds while `out_valid`=1.
  - The acceptance rule guarantees the register is free at capture.
- Arithmetic: none in this block. The product is passed through bit-exact as a signed `2*SIZE` value.

## Timing
- Handshake accepted in cycle 0. START is cycle 1, LOAD_A cycle 2, LOAD_B cycle 3.
- The multiplier iterates in cycles 4..`SIZE`+4; `mul_done` rises in cycle `SIZE`+5.
- `out_valid`=1 from cycle `SIZE`+6 (14 for `SIZE`=8). RECOVER is cycle `SIZE`+6; IDLE from `SIZE`+7.
- Back-to-back throughput: one product per `SIZE`+7 cycles when `out_ready`=1.
- A new pair is accepted in the same cycle that the old product is consumed.
- Normal WAIT length is `SIZE`+2 cycles; `TIMEOUT` must exceed this.
- Reset mid-operation: all state returns to INIT asynchronously; any product in flight is discarded. INIT resynchronises the multiplier.
- `in_valid` while not ready: the pair is ignored; the source holds it.

## Test plan
- `SIZE`=8, `in_a`=3, `in_b`=-4, `out_ready`=1 -> `out_product`=16'hFFF4, `out_valid` high exactly 14 cycles after acceptance.
- `in_a`=-128, `in_b`=-128 -> 16'h4000. `in_a`=0, `in_b`=8'h7F -> 16'h0000. `in_a`=127, `in_b`=-1 -> 16'hFF81.
- Backpressure: two pairs, `out_ready`=0 for 30 cycles -> first product held stable and `in_ready`=0 throughout. Second pair accepted in the cycle `out_ready` rises; both products correct.
- `reset_n` pulsed low during WAIT -> `out_valid`=0, `err`=0, INIT with `mul_reset`=1 for 1 cycle. The next operation 5*5 yields 16'h0019.
- Multiplier model with `mul_done` stuck at 0 -> `err`=1 after `TIMEOUT`=16 WAIT cycles, `out_valid` stays 0, sequencer returns to IDLE with `in_ready`=1.

Source files
------------

// File: rtl/booth_mul_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : booth_mul_sequencer                                           |
// | Brief    : Operand/product handshake front-end and watchdog for the      |
// |            signed Booth multiplier.                                      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module booth_mul_sequencer #(
   parameter int SIZE    = 8,
   parameter int TIMEOUT = SIZE + 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [SIZE-1:0]   in_a,
   input  logic [SIZE-1:0]   in_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [2*SIZE-1:0] out_product,
   output logic              err,
   output logic              mul_start,
   output logic              mul_reset,
   output logic [SIZE-1:0]   mul_data,
   input  logic              mul_done,
   input  logic [2*SIZE-1:0] mul_product
);

   localparam int c_CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_INIT    = 3'd0,
      S_IDLE    = 3'd1,
      S_START   = 3'd2,
      S_LOAD_A  = 3'd3,
      S_LOAD_B  = 3'd4,
      S_WAIT    = 3'd5,
      S_RECOVER = 3'd6
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [SIZE-1:0]     r_a;
   logic [SIZE-1:0]     r_b;
   logic [c_CNT_W-1:0]  r_cnt;
   logic [2*SIZE-1:0]   r_out_product;
   logic                r_out_valid;
   logic                r_err;
   logic                r_mul_start;
   logic                r_mul_reset;
   logic [SIZE-1:0]     r_mul_data;

   logic w_accept;
   logic w_consume;
   logic w_capture;
   logic w_timeout;

   assign in_ready    = (r_state == S_IDLE) && (!r_out_valid || out_ready);
   assign w_accept    = in_valid && in_ready;
   assign w_consume   = r_out_valid && out_ready;
   assign w_capture   = (r_state == S_WAIT) && mul_done;
   assign w_timeout   = (r_state == S_WAIT) && !mul_done && (r_cnt == c_CNT_LAST);

   assign out_valid   = r_out_valid;
   assign out_product = r_out_product;
   assign err         = r_err;
   assign mul_start   = r_mul_start;
   assign mul_reset   = r_mul_reset;
   assign mul_data    = r_mul_data;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_INIT:    w_next = S_IDLE;
         S_IDLE:    if (w_accept) w_next = S_START;
         S_START:   w_next = S_LOAD_A;
         S_LOAD_A:  w_next = S_LOAD_B;
         S_LOAD_B:  w_next = S_WAIT;
         S_WAIT:    if (mul_done || w_timeout) w_next = S_RECOVER;
         S_RECOVER: w_next = S_IDLE;
         default:   w_next = S_INIT;
      endcase
   end

   // Multiplier-facing outputs are decoded from the next state so they are
   // registered yet still line up with the state they belong to.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= S_INIT;
         r_a           <= '0;
         r_b           <= '0;
         r_cnt         <= '0;
         r_out_product <= '0;
         r_out_valid   <= 1'b0;
         r_err         <= 1'b0;
         r_mul_start   <= 1'b0;
         r_mul_reset   <= 1'b1;
         r_mul_data    <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_a <= in_a;
            r_b <= in_b;
         end
         if ((r_state == S_WAIT) && (w_next == S_WAIT)) begin
            r_cnt <= r_cnt + 1'b1;
         end else begin
            r_cnt <= '0;
         end
         if (w_capture) begin
            r_out_product <= mul_product;
            r_out_valid   <= 1'b1;
         end else if (w_consume) begin
            r_out_valid   <= 1'b0;
         end
         if (w_timeout) begin
            r_err <= 1'b1;
         end
         r_mul_reset <= (w_next == S_INIT) || (w_next == S_RECOVER);
         r_mul_start <= (w_next == S_START);
         case (w_next)
            S_LOAD_A: r_mul_data <= r_a;
            S_LOAD_B: r_mul_data <= r_b;
            default:  r_mul_data <= '0;
         endcase
      end
   end

endmodule
`default_nettype wire
